j1_uart_io: RTL and testbench

//  8N1 UART peripheral on the j1 CPU I/O bus (io_rd/io_wr/io_addr/io_dout/io_din).
//  - Consumes CPU I/O stores (TX bytes, control writes).
//  - Returns combinational read data for CPU I/O loads: status, RX byte, divisor.
//  - Contains a TX FIFO, a TX/RX bit engine and an RX holding stage. Sits beside main RAM in I/O space.

---
 rtl/j1_uart_io.sv | 263 ++++++++++++++++++++++++++
 tb/tb_j1_uart_io.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/j1_uart_io.sv
// 8N1 UART peripheral for the j1 CPU I/O bus: TX FIFO, TX/RX bit engines, RX holding stage.
// Define J1_UART_RX_FIFO_EN to replace the single RX holding register with a 4-entry RX FIFO.
module j1_uart_io #(
  parameter logic [15:0] CLK_DIV   = 16'd433,
  parameter int          TX_DEPTH  = 8,
  parameter logic [3:0]  IO_NIBBLE = 4'hF
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_n_i,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_dout,
  output logic [31:0] io_din,
  output logic        uart_txd,
  input  logic        uart_rxd
);
  // state   | meaning
  // S_IDLE  | line idle, waiting for a FIFO byte (TX) or a falling edge (RX)
  // S_START | start bit
  // S_DATA  | eight data bits, LSB first
  // S_STOP  | stop bit
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  localparam int TAW = $clog2(TX_DEPTH);

  logic       sel;
  logic [1:0] reg_a;
  logic       wr_data, wr_stat, wr_div, rd_data;
  logic       unused_bits;

  assign sel     = (io_addr[31:28] == IO_NIBBLE);
  assign reg_a   = io_addr[3:2];
  assign wr_data = io_wr & sel & (reg_a == 2'd0);
  assign wr_stat = io_wr & sel & (reg_a == 2'd1);
  assign wr_div  = io_wr & sel & (reg_a == 2'd2);
  assign rd_data = io_rd & sel & (reg_a == 2'd0);
  assign unused_bits = ^{io_addr[27:4], io_addr[1:0], io_dout[31:16]};

  logic [15:0] div_q;
  logic        drop_q, ferr_q, ovr_q;

  // TX FIFO, one extra pointer bit distinguishes full from empty
  logic [7:0]   tx_mem_q [TX_DEPTH];
  logic [TAW:0] tx_wp_q, tx_rp_q;
  logic         tx_empty, tx_full, tx_push, tx_pop;
  logic [7:0]   tx_head;

  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[TAW] != tx_rp_q[TAW]) && (tx_wp_q[TAW-1:0] == tx_rp_q[TAW-1:0]);
  assign tx_push  = wr_data & (~tx_full | tx_pop);
  assign tx_head  = tx_mem_q[tx_rp_q[TAW-1:0]];

  always_ff @(posedge sys_clk_i) begin
    if (tx_push) tx_mem_q[tx_wp_q[TAW-1:0]] <= io_dout[7:0];
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      tx_wp_q <= '0;
      tx_rp_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
    end
  end

  // TX engine
  state_e      tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_sh_q;
  logic        tx_cnt0, tx_idle;

  assign tx_cnt0 = (tx_cnt_q == 16'd0);
  assign tx_idle = tx_empty & (tx_state_q == S_IDLE);

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) tx_state_q <= S_IDLE;
    else              tx_state_q <= tx_state_d;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      S_IDLE:  if (!tx_empty) tx_state_d = S_START;
      S_START: if (tx_cnt0) tx_state_d = S_DATA;
      S_DATA:  if (tx_cnt0 && tx_bit_q == 3'd7) tx_state_d = S_STOP;
      S_STOP:  if (tx_cnt0) tx_state_d = tx_empty ? S_IDLE : S_START;
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_pop   = !tx_empty && ((tx_state_q == S_IDLE) || (tx_state_q == S_STOP && tx_cnt0));
    uart_txd = 1'b1;
    if (tx_state_q == S_START)     uart_txd = 1'b0;
    else if (tx_state_q == S_DATA) uart_txd = tx_sh_q[0];
  end

  // div is reloaded at every bit boundary, so DIV writes apply from the next bit
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
    end else if (tx_pop) begin
      tx_sh_q  <= tx_head;
      tx_cnt_q <= div_q;
      tx_bit_q <= '0;
    end else if (tx_state_q != S_IDLE) begin
      if (tx_cnt0) begin
        tx_cnt_q <= div_q;
        if (tx_state_q == S_DATA) begin
          tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
          tx_bit_q <= tx_bit_q + 1'b1;
        end
      end else begin
        tx_cnt_q <= tx_cnt_q - 1'b1;
      end
    end
  end

  // RX engine: s1/s2 synchronise, s3 is the delayed copy used for edge detect and sampling
  logic        rx_s1_q, rx_s2_q, rx_s3_q;
  state_e      rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_half;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_sh_q;
  logic        rx_cnt0, rx_fall, rx_deliver, rx_ferr;

  assign rx_cnt0 = (rx_cnt_q == 16'd0);
  assign rx_fall = rx_s3_q & ~rx_s2_q;
  assign rx_half = {1'b0, div_q[15:1]} + {15'd0, div_q[0]};

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= S_IDLE;
    end else begin
      rx_s1_q    <= uart_rxd;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      S_IDLE:  if (rx_fall) rx_state_d = S_START;
      S_START: if (rx_cnt0) rx_state_d = rx_s3_q ? S_IDLE : S_DATA;
      S_DATA:  if (rx_cnt0 && rx_bit_q == 3'd7) rx_state_d = S_STOP;
      S_STOP:  if (rx_cnt0) rx_state_d = S_IDLE;
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_deliver = (rx_state_q == S_STOP) & rx_cnt0 & rx_s3_q;
    rx_ferr    = (rx_state_q == S_STOP) & rx_cnt0 & ~rx_s3_q;
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
    end else if (rx_state_q == S_IDLE) begin
      rx_cnt_q <= rx_half;
      rx_bit_q <= '0;
    end else if (rx_cnt0) begin
      rx_cnt_q <= div_q;
      if (rx_state_q == S_DATA) begin
        rx_sh_q  <= {rx_s3_q, rx_sh_q[7:1]};
        rx_bit_q <= rx_bit_q + 1'b1;
      end
    end else begin
      rx_cnt_q <= rx_cnt_q - 1'b1;
    end
  end

  // RX stage
  logic [7:0] rx_byte;
  logic       rx_valid, rx_pop, rx_ovr_set;

`ifdef J1_UART_RX_FIFO_EN
  logic [7:0] rx_mem_q [4];
  logic [2:0] rx_wp_q, rx_rp_q;
  logic       rx_empty, rx_full, rx_push;

  assign rx_empty   = (rx_wp_q == rx_rp_q);
  assign rx_full    = (rx_wp_q[2] != rx_rp_q[2]) && (rx_wp_q[1:0] == rx_rp_q[1:0]);
  assign rx_pop     = rd_data & ~rx_empty;
  assign rx_push    = rx_deliver & (~rx_full | rx_pop);
  assign rx_ovr_set = rx_deliver & rx_full & ~rx_pop;
  assign rx_byte    = rx_mem_q[rx_rp_q[1:0]];
  assign rx_valid   = ~rx_empty;

  always_ff @(posedge sys_clk_i) begin
    if (rx_push) rx_mem_q[rx_wp_q[1:0]] <= rx_sh_q;
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      rx_wp_q <= '0;
      rx_rp_q <= '0;
    end else begin
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
    end
  end
`else
  logic [7:0] rx_byte_q;
  logic       rx_valid_q;

  assign rx_pop     = rd_data & rx_valid_q;
  assign rx_ovr_set = rx_deliver & rx_valid_q & ~rx_pop;
  assign rx_byte    = rx_byte_q;
  assign rx_valid   = rx_valid_q;

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
    end else if (rx_deliver && (!rx_valid_q || rx_pop)) begin
      rx_byte_q  <= rx_sh_q;
      rx_valid_q <= 1'b1;
    end else if (rx_pop) begin
      rx_valid_q <= 1'b0;
    end
  end
`endif

  // sticky flags: a set on the same edge as a clear wins
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_n_i) begin
      div_q  <= CLK_DIV;
      drop_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (wr_div) div_q <= io_dout[15:0];
      drop_q <= (wr_data & tx_full & ~tx_pop) | (drop_q & ~(wr_stat & io_dout[5]));
      ferr_q <= rx_ferr | (ferr_q & ~(wr_stat & io_dout[4]));
      ovr_q  <= rx_ovr_set | (ovr_q & ~(wr_stat & io_dout[3]));
    end
  end

  always_comb begin
    io_din = '0;
    if (sel) begin
      case (reg_a)
        2'd0:    io_din = {24'd0, rx_byte};
        2'd1:    io_din = {26'd0, drop_q, ferr_q, ovr_q, rx_valid, tx_idle, tx_full};
        2'd2:    io_din = {16'd0, div_q};
        default: io_din = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_j1_uart_io.sv
// Directed bench for j1_uart_io: register map, TX framing and FIFO, RX path, errors, decode, loopback.
// TX and RX bytes are checked through expected-byte queues filled as stimulus is driven.
module tb_j1_uart_io;
  localparam logic [31:0] A_DATA = 32'hF000_0000;
  localparam logic [31:0] A_STAT = 32'hF000_0004;
  localparam logic [31:0] A_DIV  = 32'hF000_0008;
  localparam logic [31:0] A_R3   = 32'hF000_000C;
`ifdef J1_UART_RX_FIFO_EN
  localparam int RX_CAP = 4;
`else
  localparam int RX_CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_rd = 1'b0, io_wr = 1'b0;
  logic [31:0] io_addr = '0, io_dout = '0;
  logic [31:0] io_din;
  logic        uart_txd;
  logic        rxd_drv = 1'b1, loop = 1'b0;
  logic        rxd_line;

  assign rxd_line = loop ? uart_txd : rxd_drv;
  always #5 clk = ~clk;

  j1_uart_io dut (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n), .io_rd(io_rd), .io_wr(io_wr),
    .io_addr(io_addr), .io_dout(io_dout), .io_din(io_din),
    .uart_txd(uart_txd), .uart_rxd(rxd_line)
  );

  int         n_checks = 0, n_errors = 0;
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];
  int         mon_div = 3;
  logic       mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    io_addr = a;
    #1 d = io_din;
  endtask

  task automatic io_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    io_addr = a; io_dout = d; io_wr = 1'b1;
    @(negedge clk);
    io_wr = 1'b0;
  endtask

  task automatic io_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    io_addr = a; io_rd = 1'b1;
    #1 d = io_din;
    @(negedge clk);
    io_rd = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int n);
    rxd_drv = 1'b0;
    repeat (n) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rxd_drv = b[k];
      repeat (n) @(negedge clk);
    end
    rxd_drv = stop;
    repeat (n) @(negedge clk);
    rxd_drv = 1'b1;
  endtask

  task automatic rx_pop_check(input string tag);
    logic [31:0] s, d;
    logic        ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      peek(A_STAT, s);
      if (s[2]) begin ok = 1'b1; break; end
    end
    check({tag, "_valid"}, {31'd0, ok}, 32'd1);
    if (ok) begin
      io_read(A_DATA, d);
      if (rx_exp_q.size() != 0) check(tag, d, {24'd0, rx_exp_q.pop_front()});
      else check({tag, "_unexpected"}, d, 32'hFFFF_FFFF);
    end
  endtask

  task automatic wait_tx_idle(input string tag);
    logic [31:0] s;
    logic        ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      peek(A_STAT, s);
      if (s[1]) begin ok = 1'b1; break; end
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  // serial TX decoder: finds each start bit and samples every bit mid-period
  initial begin : tx_mon
    logic       prev;
    logic [7:0] b;
    int         d, cur, t;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev === 1'b1 && uart_txd === 1'b0) begin
        d = mon_div; cur = 0;
        for (int k = 0; k < 8; k++) begin
          t = (k + 1) * (d + 1) + d / 2;
          repeat (t - cur) @(negedge clk);
          cur = t;
          b[k] = uart_txd;
        end
        t = 9 * (d + 1) + d / 2;
        repeat (t - cur) @(negedge clk);
        check("tx_stop_bit", {31'd0, uart_txd}, 32'd1);
        if (tx_exp_q.size() != 0) check("tx_byte", {24'd0, b}, {24'd0, tx_exp_q.pop_front()});
        else check("tx_unexpected", {24'd0, b}, 32'hFFFF_FFFF);
      end
      prev = uart_txd;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] s, d;
    logic [9:0]  frame;

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_txd", {31'd0, uart_txd}, 32'd1);
    peek(A_STAT, s); check("rst_stat", s, 32'h02);
    peek(A_DIV, s);  check("rst_div", s, 32'd433);
    rst_n = 1'b1;

    // single TX frame, exact bit timing
    io_write(A_DIV, 32'd3);
    mon_div = 3; mon_en = 1'b1;
    tx_exp_q.push_back(8'h55);
    io_write(A_DATA, 32'h55);
    frame = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check($sformatf("tx_level_%0d", i), {31'd0, uart_txd}, {31'd0, frame[i/4]});
    end
    peek(A_STAT, s); check("tx_busy_in_stop", {31'd0, s[1]}, 32'd0);
    @(negedge clk);
    peek(A_STAT, s); check("tx_idle_after_stop", {31'd0, s[1]}, 32'd1);

    // TX FIFO overflow: one byte in the engine plus TX_DEPTH queued, the tenth dropped
    for (int i = 0; i < 9; i++) tx_exp_q.push_back(8'h10 + 8'(i));
    @(negedge clk);
    io_addr = A_DATA; io_dout = 32'h10; io_wr = 1'b1;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      io_dout = 32'h10 + 32'(i);
    end
    @(negedge clk);
    io_wr = 1'b0;
    peek(A_STAT, s); check("tx_full_drop", s, 32'h21);
    io_write(A_STAT, 32'h20);
    peek(A_STAT, s); check("tx_drop_cleared", s, 32'h01);
    wait_tx_idle("tx_burst_drain");
    check("tx_sb_empty", tx_exp_q.size(), 32'd0);

    // RX single byte, off-nibble read must not pop
    rx_exp_q.push_back(8'hA3);
    send_byte(8'hA3, 1'b1, 4);
    repeat (10) @(negedge clk);
    peek(A_STAT, s); check("rx_valid_stat", s, 32'h06);
    io_read(32'h1000_0000, d); check("offsel_read", d, 32'h0);
    peek(A_STAT, s); check("offsel_no_pop", s, 32'h06);
    rx_pop_check("rx_a3");
    peek(A_STAT, s); check("rx_popped", s, 32'h02);

    // RX overrun: one more frame than the stage can hold
    for (int f = 0; f <= RX_CAP; f++) begin
      if (f < RX_CAP) rx_exp_q.push_back(8'h30 + 8'(f));
      send_byte(8'h30 + 8'(f), 1'b1, 4);
      if (f == RX_CAP - 1) begin
        repeat (20) @(negedge clk);
        peek(A_STAT, s); check("rx_no_overrun_yet", {31'd0, s[3]}, 32'd0);
      end
    end
    repeat (20) @(negedge clk);
    peek(A_STAT, s); check("rx_overrun", s, 32'h0E);
    for (int f = 0; f < RX_CAP; f++) rx_pop_check($sformatf("rx_ovr_byte%0d", f));
    peek(A_STAT, s); check("rx_ovr_drained", s, 32'h0A);
    io_write(A_STAT, 32'h08);
    peek(A_STAT, s); check("rx_ovr_cleared", s, 32'h02);

    // glitch reject and frame error
    @(negedge clk); rxd_drv = 1'b0;
    @(negedge clk); rxd_drv = 1'b1;
    repeat (20) @(negedge clk);
    peek(A_STAT, s); check("rx_glitch", s, 32'h02);
    send_byte(8'h5A, 1'b0, 4);
    repeat (20) @(negedge clk);
    peek(A_STAT, s); check("rx_frame_err", s, 32'h12);
    io_write(A_STAT, 32'h10);
    peek(A_STAT, s); check("rx_ferr_cleared", s, 32'h02);

    // decode: off-nibble accesses change nothing
    io_write(32'h0000_0000, 32'h77);
    io_write(32'h7000_0008, 32'h5);
    repeat (5) @(negedge clk);
    peek(A_STAT, s);         check("offsel_no_push", s, 32'h02);
    peek(A_DIV, s);          check("offsel_div_kept", s, 32'd3);
    peek(32'hE000_0004, s);  check("offsel_stat_zero", s, 32'h0);
    peek(32'h0000_0008, s);  check("offsel_div_zero", s, 32'h0);
    peek(A_R3, s);           check("reg3_zero", s, 32'h0);

    // loopback at one clock per bit
    loop = 1'b1;
    io_write(A_DIV, 32'd0);
    mon_div = 0;
    tx_exp_q.push_back(8'h3C);
    rx_exp_q.push_back(8'h3C);
    io_write(A_DATA, 32'h3C);
    rx_pop_check("loopback");
    wait_tx_idle("loop_tx_idle");
    loop = 1'b0;

    // reset in the middle of a TX frame
    mon_en = 1'b0;
    io_write(A_DIV, 32'd3);
    io_write(A_DATA, 32'hF0);
    repeat (10) @(negedge clk);
    check("midframe_txd_low", {31'd0, uart_txd}, 32'd0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_txd", {31'd0, uart_txd}, 32'd1);
    rst_n = 1'b1;
    peek(A_STAT, s); check("midrst_stat", s, 32'h02);
    peek(A_DIV, s);  check("midrst_div", s, 32'd433);
    repeat (50) @(negedge clk);
    check("midrst_txd_stays", {31'd0, uart_txd}, 32'd1);

    check("tx_sb_final", tx_exp_q.size(), 32'd0);
    check("rx_sb_final", rx_exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
